// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Direct-mapped BTB with per-entry saturating direction counters.
//   Fetch side: combinational lookup on f_pc.
//   Execute side: resolves RV32I conditional branches, flags mispredicts,
//   drives a registered redirect PC and trains the table.
//   Optional feature macro: BRU_PERF_COUNTERS_EN adds the 32-bit
//   perf_branches / perf_mispredicts counters.
//   Reset is synchronous and active-high.
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_BITS    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_hit,
  output logic            f_pred_taken,
  output logic [XLEN-1:0] f_pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
`ifdef BRU_PERF_COUNTERS_EN
  output logic            illegal_br,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`else
  output logic            illegal_br
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // Weakly-taken: MSB set, rest clear. Weakly-not-taken is one below it.
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // BTB storage
  logic                valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]    tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]     target_q [BTB_ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [BTB_ENTRIES];

  // Fetch-side lookup
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [XLEN-1:0]  f_seq_pc;

  assign f_idx    = f_pc[IDX_W+1:2];
  assign f_tag    = f_pc[XLEN-1:IDX_W+2];
  assign f_seq_pc = f_pc + XLEN'(4);

  // Read the current table contents; same-cycle writes appear next cycle.
  always_comb begin
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_pred_taken  = f_hit && ctr_q[f_idx][CTR_BITS-1];
    f_pred_target = f_pred_taken ? target_q[f_idx] : f_seq_pc;
  end

  // Execute-side resolution
  logic             br_taken;
  logic             br_legal;
  logic [XLEN-1:0]  actual_target;
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  actual_next;
  logic             resolve;
  logic             mispredict_d;

  assign actual_target = ex_pc + ex_imm;
  assign seq_pc        = ex_pc + XLEN'(4);
  assign actual_next   = br_taken ? actual_target : seq_pc;

  // Branch condition evaluation; funct3 010/011 are not branches.
  always_comb begin
    br_taken = 1'b0;
    br_legal = 1'b1;
    case (ex_funct3)
      F3_BEQ:  br_taken = (ex_rs1 == ex_rs2);
      F3_BNE:  br_taken = (ex_rs1 != ex_rs2);
      F3_BLT:  br_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      F3_BGE:  br_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: br_taken = (ex_rs1 <  ex_rs2);
      F3_BGEU: br_taken = (ex_rs1 >= ex_rs2);
      default: br_legal = 1'b0;
    endcase
  end

  assign resolve      = ex_valid && br_legal;
  assign mispredict_d = resolve &&
                        ((ex_pred_taken != br_taken) ||
                         (ex_pred_target != actual_next));

  // Registered redirect strobe, redirect target and illegal-branch flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict  <= 1'b0;
      illegal_br  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mispredict_d;
      illegal_br <= ex_valid && !br_legal;
      if (mispredict_d) begin
        redirect_pc <= actual_next;
      end
    end
  end

  // Training: entry addressed by the executing branch
  logic [IDX_W-1:0]    e_idx;
  logic [TAG_W-1:0]    e_tag;
  logic                e_hit;
  logic                wr_en;
  logic [XLEN-1:0]     wr_target;
  logic [CTR_BITS-1:0] wr_ctr;

  assign e_idx = ex_pc[IDX_W+1:2];
  assign e_tag = ex_pc[XLEN-1:IDX_W+2];
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  // Compute the updated entry: counter step on hit, allocate on taken miss.
  always_comb begin
    wr_en     = 1'b0;
    wr_target = target_q[e_idx];
    wr_ctr    = ctr_q[e_idx];
    if (resolve) begin
      if (e_hit) begin
        wr_en = 1'b1;
        if (br_taken) begin
          wr_target = actual_target;
          if (ctr_q[e_idx] != CTR_MAX) begin
            wr_ctr = ctr_q[e_idx] + CTR_BITS'(1);
          end
        end else if (ctr_q[e_idx] != CTR_MIN) begin
          wr_ctr = ctr_q[e_idx] - CTR_BITS'(1);
        end
      end else if (br_taken) begin
        wr_en     = 1'b1;
        wr_target = actual_target;
        wr_ctr    = CTR_WT;
      end
    end
  end

  // Table state; reset wins over any update pending in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_q[e_idx]  <= 1'b1;
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= wr_target;
      ctr_q[e_idx]    <= wr_ctr;
    end
  end

`ifdef BRU_PERF_COUNTERS_EN
  // Event counters: resolved legal branches and issued redirect pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (resolve) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (mispredict) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit (default parameters:
// XLEN=32, BTB_ENTRIES=16, CTR_BITS=2).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_pc;
  logic        f_hit;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_imm;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        illegal_br;
`ifdef BRU_PERF_COUNTERS_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  branch_resolve_unit dut (
    .clk            (clk),
    .reset          (reset),
    .f_pc           (f_pc),
    .f_hit          (f_hit),
    .f_pred_taken   (f_pred_taken),
    .f_pred_target  (f_pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_funct3      (ex_funct3),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_imm         (ex_imm),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
`ifdef BRU_PERF_COUNTERS_EN
    .illegal_br       (illegal_br),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`else
    .illegal_br     (illegal_br)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic pt,
                       input logic [31:0] ptgt);
    ex_pc          = pc;
    ex_funct3      = f3;
    ex_rs1         = a;
    ex_rs2         = b;
    ex_imm         = imm;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
    ex_valid       = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic br(input logic [31:0] pc, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] imm, input logic pt,
                    input logic [31:0] ptgt);
    drive(pc, f3, a, b, imm, pt, ptgt);
    tick();
  endtask

  task automatic look(input logic [31:0] pc);
    f_pc = pc;
    #1;
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; f_pc = 32'h100;
    ex_pc = '0; ex_funct3 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    look(32'h100);
    chk("rst_f_hit", f_hit, 0);
    chk("rst_f_pred_taken", f_pred_taken, 0);
    chk("rst_f_pred_target", f_pred_target, 32'h104);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_illegal_br", illegal_br, 0);

    // BEQ cold miss, with same-cycle lookup at the same index
    drive(32'h100, 3'b000, 5, 5, 32'h40, 1'b0, 32'h104);
    #1;
    chk("rbw_old_hit", f_hit, 0);
    tick();
    chk("cold_mispredict", mispredict, 1);
    chk("cold_redirect", redirect_pc, 32'h140);
    chk("cold_f_hit", f_hit, 1);
    chk("cold_f_pred_taken", f_pred_taken, 1);
    chk("cold_f_pred_target", f_pred_target, 32'h140);
    tick();
    chk("pulse_mispredict", mispredict, 0);
    chk("hold_redirect", redirect_pc, 32'h140);

    // Counter training at 0x100 (ctr 2 after allocation)
    br(32'h100, 3'b000, 5, 6, 32'h40, 1'b0, 32'h104);           // ctr 1
    chk("nt_mispredict", mispredict, 0);
    chk("nt_f_pred_taken", f_pred_taken, 0);
    chk("nt_f_pred_target", f_pred_target, 32'h104);
    chk("nt_hold_redirect", redirect_pc, 32'h140);
    br(32'h100, 3'b000, 5, 5, 32'h40, 1'b0, 32'h104);           // ctr 2
    chk("t1_mispredict", mispredict, 1);
    chk("t1_f_pred_taken", f_pred_taken, 1);
    br(32'h100, 3'b000, 5, 5, 32'h40, 1'b1, 32'h140);           // ctr 3
    chk("t2_mispredict", mispredict, 0);
    br(32'h100, 3'b000, 5, 5, 32'h40, 1'b1, 32'h150);           // ctr 3, wrong target
    chk("tgt_mispredict", mispredict, 1);
    chk("tgt_redirect", redirect_pc, 32'h140);
    br(32'h100, 3'b000, 5, 6, 32'h40, 1'b1, 32'h140);           // ctr 2
    chk("sat_hi_mispredict", mispredict, 1);
    chk("sat_hi_redirect", redirect_pc, 32'h104);
    chk("sat_hi_f_pred_taken", f_pred_taken, 1);
    br(32'h100, 3'b000, 5, 6, 32'h40, 1'b1, 32'h140);           // ctr 1
    chk("dec1_f_pred_taken", f_pred_taken, 0);
    br(32'h100, 3'b000, 5, 6, 32'h40, 1'b0, 32'h104);           // ctr 0
    chk("dec0_mispredict", mispredict, 0);
    br(32'h100, 3'b000, 5, 6, 32'h40, 1'b0, 32'h104);           // ctr stays 0
    chk("sat_lo_f_pred_taken", f_pred_taken, 0);
    br(32'h100, 3'b000, 5, 5, 32'h40, 1'b0, 32'h104);           // ctr 1
    chk("inc_lo_mispredict", mispredict, 1);
    chk("inc_lo_f_pred_taken", f_pred_taken, 0);

    // Signed vs unsigned compares, rs1=0xFFFFFFFF rs2=1
    br(32'h208, 3'b100, 32'hFFFF_FFFF, 1, 32'h20, 1'b0, 32'h20C);
    chk("blt_mispredict", mispredict, 1);
    chk("blt_redirect", redirect_pc, 32'h228);
    br(32'h30C, 3'b110, 32'hFFFF_FFFF, 1, 32'h20, 1'b1, 32'h32C);
    chk("bltu_mispredict", mispredict, 1);
    chk("bltu_redirect", redirect_pc, 32'h310);
    look(32'h30C);
    chk("bltu_no_alloc", f_hit, 0);
    br(32'h410, 3'b101, 32'hFFFF_FFFF, 1, 32'h20, 1'b1, 32'h430);
    chk("bge_redirect", redirect_pc, 32'h414);
    br(32'h514, 3'b111, 32'hFFFF_FFFF, 1, 32'h20, 1'b0, 32'h518);
    chk("bgeu_redirect", redirect_pc, 32'h534);
    br(32'h618, 3'b001, 3, 4, 32'hFFFF_FFF0, 1'b0, 32'h61C);
    chk("bne_back_redirect", redirect_pc, 32'h608);
    look(32'h618);
    chk("bne_f_pred_target", f_pred_target, 32'h608);

    // PC+4 wraps at 2^32
    br(32'hFFFF_FFFC, 3'b000, 1, 2, 32'h40, 1'b1, 32'h0);
    chk("wrap_mispredict", mispredict, 1);
    chk("wrap_redirect", redirect_pc, 32'h0);

    // Aliasing: 0x140 shares index 0 with 0x100
    br(32'h140, 3'b000, 7, 7, 32'h40, 1'b0, 32'h144);
    chk("alias_redirect", redirect_pc, 32'h180);
    look(32'h100);
    chk("alias_old_hit", f_hit, 0);
    look(32'h140);
    chk("alias_new_hit", f_hit, 1);
    chk("alias_new_pred_taken", f_pred_taken, 1);
    chk("alias_new_target", f_pred_target, 32'h180);

    // Illegal funct3
    br(32'h140, 3'b010, 7, 7, 32'h80, 1'b0, 32'h144);
    chk("ill_illegal_br", illegal_br, 1);
    chk("ill_mispredict", mispredict, 0);
    chk("ill_hold_redirect", redirect_pc, 32'h180);
    chk("ill_no_write", f_pred_target, 32'h180);
    tick();
    chk("ill_pulse", illegal_br, 0);
    br(32'h71C, 3'b011, 7, 7, 32'h80, 1'b0, 32'h720);
    chk("ill011_illegal_br", illegal_br, 1);
    look(32'h71C);
    chk("ill011_no_alloc", f_hit, 0);

    // ex_valid low: nothing happens
    drive(32'h724, 3'b000, 1, 1, 32'h40, 1'b0, 32'h728);
    ex_valid = 1'b0;
    tick();
    chk("noval_mispredict", mispredict, 0);
    chk("noval_illegal_br", illegal_br, 0);
    look(32'h724);
    chk("noval_no_alloc", f_hit, 0);

    // Reset mid-operation discards the pending branch
    drive(32'h728, 3'b000, 1, 1, 32'h40, 1'b0, 32'h72C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_mispredict", mispredict, 0);
    chk("rst2_redirect", redirect_pc, 0);
    look(32'h728);
    chk("rst2_no_alloc", f_hit, 0);
    look(32'h140);
    chk("rst2_cleared", f_hit, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Next-generation branch detector. It holds a parametrised direct-mapped BTB with per-entry saturating direction counters, and serves a combinational fetch-stage prediction. It resolves all six RV32I conditional branches in execute, flags mispredicts, drives a registered redirect PC, and trains the table. It sits between the fetch PC mux and the execute stage.

Parameters:
XLEN, 32, data and address width
BTB_ENTRIES, 16, BTB depth; power of 2, at least 2; IDX_W = log2(BTB_ENTRIES)
CTR_BITS, 2, direction counter width; counter MSB = predict taken

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
f_pc  input  XLEN  fetch PC to look up
f_hit  output  1  valid entry with matching tag
f_pred_taken  output  1  f_hit AND counter MSB set
f_pred_target  output  XLEN  stored target; f_pc+4 when f_pred_taken=0
ex_valid  input  1  a branch is in execute this cycle
ex_pc  input  XLEN  PC of the branch
ex_funct3  input  3  branch type
ex_rs1  input  XLEN  operand 1
ex_rs2  input  XLEN  operand 2
ex_imm  input  XLEN  sign-extended B-immediate
ex_pred_taken  input  1  prediction carried with the instruction
ex_pred_target  input  XLEN  predicted next PC carried with the instruction
mispredict  output  1  registered redirect strobe
redirect_pc  output  XLEN  registered correct next PC
illegal_br  output  1  registered; ex_valid with funct3 010 or 011

Behaviour:
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. Each entry holds valid, tag, target and counter.
- Lookup is combinational on f_pc, read-before-write: an update to the same idx in the same cycle is seen next cycle.
- Condition by funct3:
  - 000 BEQ: rs1==rs2
  - 001 BNE: rs1!=rs2
  - 100 BLT: signed rs1<rs2
  - 101 BGE: signed rs1>=rs2
  - 110 BLTU: unsigned rs1<rs2
  - 111 BGEU: unsigned rs1>=rs2
- Outcome: actual_target = ex_pc+ex_imm, modulo 2^XLEN. actual_next = actual_target if taken, else ex_pc+4; the +4 wraps at 2^XLEN.
- Mispredict condition: ex_valid AND legal funct3 AND (ex_pred_taken != taken OR ex_pred_target != actual_next).
- Latency: mispredict, redirect_pc and illegal_br register one cycle after the ex_valid cycle.
  - mispredict is a 1-cycle pulse.
  - redirect_pc = actual_next on mispredict; otherwise it holds its previous value.
- Training: on a legal ex_valid, the table is written at the clock edge.
  - Tag hit: counter saturating +1 if taken, -1 if not taken. Target is overwritten with actual_target when taken.
  - Tag miss or invalid entry, taken: allocate. valid=1, new tag, target=actual_target, counter = weakly-taken (MSB=1, rest 0).
  - Tag miss or invalid entry, not taken: no allocation, table unchanged.
  - Counter saturates at 0 and at 2^CTR_BITS-1; no wrap.
- Illegal funct3 (010/011): no mispredict, no table write. illegal_br pulses 1 cycle.
- ex_valid=0: outputs mispredict and illegal_br are 0 next cycle; table unchanged.
- Reset values: mispredict=0, illegal_br=0, redirect_pc=0. All valid bits=0, counters=weakly-not-taken (MSB=0, rest 1), targets=0, tags=0.
- Reset mid-operation: a pending ex_valid in the reset cycle is discarded; no table write occurs.

Optional Feature:
Macro BRU_PERF_COUNTERS_EN.
- Defined: adds outputs perf_branches and perf_mispredicts, each 32 bits, both reset to 0.
  - perf_branches increments on each legal ex_valid.
  - perf_mispredicts increments with each mispredict pulse.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then f_pc=0x100 -> f_hit=0, f_pred_taken=0, f_pred_target=0x104. mispredict=0, redirect_pc=0.
- BEQ cold miss: ex_pc=0x100, rs1=rs2=5, imm=0x40, pred_taken=0, pred_target=0x104 -> next cycle mispredict=1, redirect_pc=0x140. Then f_pc=0x100 -> f_hit=1, f_pred_taken=1, f_pred_target=0x140.
- Counter training at 0x100 after allocation: a not-taken BEQ with correct pred_taken=0 -> mispredict=0. Then f_pc=0x100 -> f_pred_taken=0. Two taken outcomes -> counter saturates at 3. A further taken outcome -> counter stays 3.
- Signed vs unsigned compare: rs1=0xFFFFFFFF, rs2=1. BLT is taken (target ex_pc+imm); BLTU is not taken (redirect ex_pc+4) when predicted the opposite way. BGE/BGEU give the complementary outcomes.
- Aliasing: allocate 0x100, then a taken branch at 0x100+4*BTB_ENTRIES -> tag replaced. f_pc=0x100 -> f_hit=0.
- funct3=010 with ex_valid -> illegal_br=1 for 1 cycle, mispredict=0, no table change. Same-cycle lookup/update at one idx -> old value seen that cycle, new value the next.
